// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared MIPS constants, instruction field helpers, fetch states.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int c_INSTR_W   = 32;
   localparam int c_OPCODE_HI = 31;
   localparam int c_OPCODE_LO = 26;
   localparam int c_FUNCT_HI  = 5;
   localparam int c_FUNCT_LO  = 0;

   // sll $0,$0,0
   localparam logic [c_INSTR_W-1:0] c_NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0] c_OPC_J   = 6'h02;
   localparam logic [5:0] c_OPC_JAL = 6'h03;
   localparam logic [5:0] c_OPC_BEQ = 6'h04;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetchState_t;

   function automatic logic [5:0] opcodeOf(input logic [c_INSTR_W-1:0] instr);
      return instr[c_OPCODE_HI:c_OPCODE_LO];
   endfunction

   function automatic logic [5:0] functOf(input logic [c_INSTR_W-1:0] instr);
      return instr[c_FUNCT_HI:c_FUNCT_LO];
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
//  Module   : if_id_reg
//  Brief    : IF/ID holding register with load, consume and flush controls.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [c_INSTR_W-1:0] NOP_INSTR = c_NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_load,
   input  logic [c_INSTR_W-1:0] i_instr,
   input  logic [31:0]          i_pc,
   input  logic                 i_consume,
   input  logic                 i_flush,
   output logic                 o_valid,
   output logic [c_INSTR_W-1:0] o_instr,
   output logic [31:0]          o_pc,
   output logic [31:0]          o_pcPlus4
);

   // Flush outranks load so a redirect always discards a same-cycle response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid   <= 1'b0;
         o_instr   <= NOP_INSTR;
         o_pc      <= 32'h0000_0000;
         o_pcPlus4 <= 32'h0000_0004;
      end else if (i_flush) begin
         o_valid <= 1'b0;
         o_instr <= NOP_INSTR;
      end else if (i_load) begin
         o_valid   <= 1'b1;
         o_instr   <= i_instr;
         o_pc      <= i_pc;
         o_pcPlus4 <= i_pc + 32'd4;
      end else if (i_consume) begin
         o_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
//  Module   : if_fetch_stage
//  Brief    : MIPS instruction fetch: PC, single-outstanding imem request, IF/ID slot.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0]          RESET_PC  = 32'h0000_0000,
   parameter logic [c_INSTR_W-1:0] NOP_INSTR = c_NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [31:0]          imem_addr,
   input  logic                 imem_ready,
   input  logic                 imem_rvalid,
   input  logic [c_INSTR_W-1:0] imem_rdata,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   output logic                 id_valid,
   input  logic                 id_ready,
   output logic [c_INSTR_W-1:0] id_instr,
   output logic [31:0]          id_pc,
   output logic [31:0]          id_pc_plus4,
   output logic [5:0]           id_opcode,
   output logic [5:0]           id_funct
);

   fetchState_t r_state, w_nextState;
   logic [31:0] r_pc, w_pcNext;
   logic [31:0] r_reqPc, w_reqPcNext;
   logic        w_slotFree, w_accept, w_consume, w_load;

   assign w_slotFree = !id_valid || id_ready;
   assign imem_req   = (r_state == REQ) && w_slotFree && !redirect_valid && !reset;
   assign imem_addr  = r_pc;
   assign w_accept   = imem_req && imem_ready;
   assign w_consume  = id_valid && id_ready;

   always_comb begin
      w_nextState = r_state;
      w_pcNext    = r_pc;
      w_reqPcNext = r_reqPc;
      w_load      = 1'b0;
      if (redirect_valid) begin
         w_pcNext = redirect_pc & ~32'h0000_0003;
         // An in-flight response must still be absorbed before fetching the target.
         case (r_state)
            WAIT, DRAIN: w_nextState = imem_rvalid ? REQ : DRAIN;
            default:     w_nextState = REQ;
         endcase
      end else begin
         case (r_state)
            REQ: begin
               if (w_accept) begin
                  w_reqPcNext = r_pc;
                  w_pcNext    = r_pc + 32'd4;
                  w_nextState = WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  w_load      = 1'b1;
                  w_nextState = REQ;
               end
            end
            DRAIN: begin
               if (imem_rvalid) w_nextState = REQ;
            end
            default: w_nextState = REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= REQ;
         r_pc    <= RESET_PC;
         r_reqPc <= RESET_PC;
      end else begin
         r_state <= w_nextState;
         r_pc    <= w_pcNext;
         r_reqPc <= w_reqPcNext;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifIdReg (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_instr   (imem_rdata),
      .i_pc      (r_reqPc),
      .i_consume (w_consume),
      .i_flush   (redirect_valid),
      .o_valid   (id_valid),
      .o_instr   (id_instr),
      .o_pc      (id_pc),
      .o_pcPlus4 (id_pc_plus4)
   );

   assign id_opcode = opcodeOf(id_instr);
   assign id_funct  = functOf(id_instr);

endmodule

`default_nettype wire
